// File: rtl/lfsr_sched.sv
// lfsr_sched: seeds and warms up an external LFSR, then hands out fresh random
// words to two requesters with round-robin arbitration, one grant per two cycles.
// A tamper alarm locks the block until it is reseeded with the alarm low.
// Optional feature: define LFSR_SCHED_WORD_CNT_EN to add the o_word_cnt grant counter.
module lfsr_sched #(
  parameter int NUM_BITS = 32,
  parameter int WARMUP   = 16
) (
  input  logic                i_Clk,
  input  logic                i_rst,
  input  logic                i_seed_dv,
  input  logic [NUM_BITS-1:0] i_seed_data,
  input  logic [1:0]          i_req,
  output logic [1:0]          o_gnt,
  output logic [NUM_BITS-1:0] o_data,
  input  logic [NUM_BITS-1:0] i_lfsr_data,
  output logic                o_lfsr_enable,
  output logic                o_lfsr_seed_dv,
  output logic [NUM_BITS-1:0] o_lfsr_seed_data,
  input  logic                i_alarm,
`ifdef LFSR_SCHED_WORD_CNT_EN
  output logic [15:0]         o_word_cnt,
`endif
  output logic                o_ready,
  output logic                o_locked
);

  typedef enum logic [2:0] {
    S_UNSEEDED = 3'd0,
    S_SEED     = 3'd1,
    S_WARMUP   = 3'd2,
    S_READY    = 3'd3,
    S_GRANT    = 3'd4,
    S_ALARM    = 3'd5
  } state_t;

  // Counter value reached during the last warm-up cycle.
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_t              state_reg, state_next;
  logic [7:0]          warm_reg, warm_next;
  logic                last_reg, last_next;   // index of the requester granted last
  logic [1:0]          win;
  logic [1:0]          gnt_next;
  logic [NUM_BITS-1:0] data_next;
  logic                enable_next;
  logic                seed_dv_next;
  logic [NUM_BITS-1:0] seed_data_next;
  logic                ready_next;
  logic                locked_next;

  // Round-robin winner: a lone requester wins, on contention the one not granted last.
  always_comb begin
    win = 2'b00;
    case (i_req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_reg ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  // Next-state logic; alarm overrides everything, seed overrides a pending request.
  always_comb begin
    state_next = state_reg;
    warm_next  = warm_reg;
    last_next  = last_reg;
    if (i_alarm) begin
      state_next = S_ALARM;
    end else begin
      case (state_reg)
        S_UNSEEDED: if (i_seed_dv) state_next = S_SEED;
        S_SEED: begin
          state_next = S_WARMUP;
          warm_next  = '0;
        end
        S_WARMUP: begin
          if (i_seed_dv) begin
            state_next = S_SEED;
          end else if (warm_reg == WARM_LAST) begin
            state_next = S_READY;
            warm_next  = '0;
          end else begin
            warm_next = warm_reg + 8'd1;
          end
        end
        S_READY: begin
          if (i_seed_dv) begin
            state_next = S_SEED;
          end else if (|i_req) begin
            state_next = S_GRANT;
            last_next  = win[1];
          end
        end
        S_GRANT:    state_next = i_seed_dv ? S_SEED : S_READY;
        S_ALARM:    if (i_seed_dv) state_next = S_SEED;
        default:    state_next = S_UNSEEDED;
      endcase
    end
  end

  // Output values for the state being entered, so registered outputs line up with the state.
  always_comb begin
    gnt_next       = 2'b00;
    data_next      = '0;
    enable_next    = 1'b0;
    seed_dv_next   = 1'b0;
    seed_data_next = o_lfsr_seed_data;
    ready_next     = 1'b0;
    locked_next    = 1'b0;
    case (state_next)
      S_SEED: begin
        enable_next    = 1'b1;
        seed_dv_next   = 1'b1;
        seed_data_next = i_seed_data;
      end
      S_WARMUP: enable_next = 1'b1;
      S_READY:  ready_next  = 1'b1;
      S_GRANT: begin
        // The LFSR advances during GRANT so the next word is always fresh.
        enable_next = 1'b1;
        gnt_next    = win;
        data_next   = i_lfsr_data;
      end
      S_ALARM:  locked_next = 1'b1;
      default:  ;
    endcase
  end

  // State, warm-up counter, round-robin pointer and all registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_reg        <= S_UNSEEDED;
      warm_reg         <= '0;
      last_reg         <= 1'b1;   // requester 0 wins the first contention
      o_gnt            <= 2'b00;
      o_data           <= '0;
      o_lfsr_enable    <= 1'b0;
      o_lfsr_seed_dv   <= 1'b0;
      o_lfsr_seed_data <= '0;
      o_ready          <= 1'b0;
      o_locked         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      warm_reg         <= warm_next;
      last_reg         <= last_next;
      o_gnt            <= gnt_next;
      o_data           <= data_next;
      o_lfsr_enable    <= enable_next;
      o_lfsr_seed_dv   <= seed_dv_next;
      o_lfsr_seed_data <= seed_data_next;
      o_ready          <= ready_next;
      o_locked         <= locked_next;
    end
  end

`ifdef LFSR_SCHED_WORD_CNT_EN
  // Saturating grant counter, cleared whenever a new seed is taken.
  always_ff @(posedge i_Clk) begin
    if (i_rst || state_next == S_SEED) begin
      o_word_cnt <= 16'd0;
    end else if (state_next == S_GRANT && o_word_cnt != 16'hFFFF) begin
      o_word_cnt <= o_word_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: self-checking bench for lfsr_sched with a behavioural LFSR and
// a reference model that predicts each word from the seed and the advance count.
module tb_lfsr_sched;

  localparam int NB = 32;
  localparam int WU = 4;

  logic          i_Clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_seed_dv = 1'b0;
  logic [NB-1:0] i_seed_data = '0;
  logic [1:0]    i_req = 2'b00;
  logic [1:0]    o_gnt;
  logic [NB-1:0] o_data;
  logic [NB-1:0] i_lfsr_data;
  logic          o_lfsr_enable;
  logic          o_lfsr_seed_dv;
  logic [NB-1:0] o_lfsr_seed_data;
  logic          i_alarm = 1'b0;
  logic          o_ready;
  logic          o_locked;
`ifdef LFSR_SCHED_WORD_CNT_EN
  logic [15:0]   o_word_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [NB-1:0] cur_seed = '0;
  int            grants = 0;     // grants since the last seed
  int            last_idx = 1;   // requester granted last

  lfsr_sched #(.NUM_BITS(NB), .WARMUP(WU)) dut (
    .i_Clk(i_Clk),
    .i_rst(i_rst),
    .i_seed_dv(i_seed_dv),
    .i_seed_data(i_seed_data),
    .i_req(i_req),
    .o_gnt(o_gnt),
    .o_data(o_data),
    .i_lfsr_data(i_lfsr_data),
    .o_lfsr_enable(o_lfsr_enable),
    .o_lfsr_seed_dv(o_lfsr_seed_dv),
    .o_lfsr_seed_data(o_lfsr_seed_data),
    .i_alarm(i_alarm),
`ifdef LFSR_SCHED_WORD_CNT_EN
    .o_word_cnt(o_word_cnt),
`endif
    .o_ready(o_ready),
    .o_locked(o_locked)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [NB-1:0] lfsr_step(input logic [NB-1:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Word seen after n advances of a freshly loaded seed.
  function automatic logic [NB-1:0] expected_word(input logic [NB-1:0] s, input int n);
    logic [NB-1:0] v = s;
    for (int k = 0; k < n; k++) v = lfsr_step(v);
    return v;
  endfunction

  function automatic logic [1:0] model_winner(input logic [1:0] pend, input int last);
    if (pend == 2'b11) return (last == 0) ? 2'b10 : 2'b01;
    return pend;
  endfunction

  // External LFSR driven by the scheduler's strobes
  logic [NB-1:0] lfsr = 32'h1;
  always @(posedge i_Clk) begin
    if (o_lfsr_enable) lfsr <= o_lfsr_seed_dv ? o_lfsr_seed_data : lfsr_step(lfsr);
  end
  assign i_lfsr_data = lfsr;

  task automatic tick();
    @(negedge i_Clk);
  endtask

  task automatic do_seed(input logic [NB-1:0] s);
    i_seed_dv = 1'b1; i_seed_data = s;
    tick();
    i_seed_dv = 1'b0;
    cur_seed = s; grants = 0;
    repeat (WU + 1) tick();
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL seed_ready: o_ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({o_gnt, o_data, o_lfsr_enable, o_lfsr_seed_dv, o_lfsr_seed_data, o_ready, o_locked} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: gnt=%b data=%h en=%b sdv=%b sd=%h rdy=%b lck=%b required all 0",
               o_gnt, o_data, o_lfsr_enable, o_lfsr_seed_dv, o_lfsr_seed_data, o_ready, o_locked);
    end
    i_rst = 1'b0;
    i_req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (o_gnt !== 2'b00 || o_ready !== 1'b0) begin
        miscompares++; $display("FAIL unseeded_idle: gnt=%b ready=%b required 00/0", o_gnt, o_ready);
      end
    end
    i_req = 2'b00;
  endtask

  task automatic test_seed_to_ready();
    i_seed_dv = 1'b1; i_seed_data = 32'h0000_00A5;
    for (int c = 1; c <= WU + 2; c++) begin
      tick();
      i_seed_dv = 1'b0;
      vectors++;
      if (o_lfsr_seed_dv !== (c == 1) || o_lfsr_enable !== (c <= WU + 1) || o_ready !== (c == WU + 2)) begin
        miscompares++;
        $display("FAIL seed_to_ready cycle %0d: sdv=%b en=%b rdy=%b required %b/%b/%b", c,
                 o_lfsr_seed_dv, o_lfsr_enable, o_ready, c == 1, c <= WU + 1, c == WU + 2);
      end
      if (c == 1) begin
        vectors++;
        if (o_lfsr_seed_data !== 32'h0000_00A5) begin
          miscompares++; $display("FAIL seed_data: got %h required 000000a5", o_lfsr_seed_data);
        end
      end
    end
    cur_seed = 32'h0000_00A5; grants = 0;
  endtask

  task automatic test_contention();
    logic [NB-1:0] seen[$];
    logic [1:0] exp_g;
    i_req = 2'b11;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 2 == 1) begin
        exp_g = model_winner(2'b11, last_idx);
        vectors++;
        if (o_gnt !== exp_g || o_data !== expected_word(cur_seed, WU + grants)) begin
          miscompares++;
          $display("FAIL contention cycle %0d: gnt=%b data=%h required %b/%h", c, o_gnt, o_data,
                   exp_g, expected_word(cur_seed, WU + grants));
        end
        foreach (seen[k]) begin
          vectors++;
          if (seen[k] === o_data) begin
            miscompares++; $display("FAIL distinct_word: %h repeated, required new value", o_data);
          end
        end
        seen.push_back(o_data);
        $display("grant %b data %h", o_gnt, o_data);
        last_idx = exp_g[1] ? 1 : 0; grants++;
      end else begin
        vectors++;
        if (o_gnt !== 2'b00 || o_ready !== 1'b1) begin
          miscompares++; $display("FAIL contention_gap cycle %0d: gnt=%b ready=%b required 00/1", c, o_gnt, o_ready);
        end
      end
    end
    i_req = 2'b00;
  endtask

  task automatic test_random_requests();
    logic [1:0] pend = 2'b00;
    logic [1:0] exp_g;
    for (int it = 0; it < 30; it++) begin
      pend = pend | 2'($urandom_range(0, 3));
      i_req = pend;
      tick();
      if (pend == 2'b00) begin
        vectors++;
        if (o_gnt !== 2'b00 || o_ready !== 1'b1) begin
          miscompares++; $display("FAIL idle_ready: gnt=%b ready=%b required 00/1", o_gnt, o_ready);
        end
        continue;
      end
      exp_g = model_winner(pend, last_idx);
      vectors++;
      if (o_gnt !== exp_g || o_data !== expected_word(cur_seed, WU + grants) || o_lfsr_enable !== 1'b1) begin
        miscompares++;
        $display("FAIL random_grant req=%b: gnt=%b data=%h en=%b required %b/%h/1", pend, o_gnt, o_data,
                 o_lfsr_enable, exp_g, expected_word(cur_seed, WU + grants));
      end
      $display("grant %b data %h", o_gnt, o_data);
      last_idx = exp_g[1] ? 1 : 0; grants++;
      pend = pend & ~exp_g;
      i_req = pend;
      tick();
      vectors++;
      if (o_gnt !== 2'b00 || o_ready !== 1'b1) begin
        miscompares++; $display("FAIL grant_clear: gnt=%b ready=%b required 00/1", o_gnt, o_ready);
      end
    end
    i_req = 2'b00;
  endtask

  task automatic test_seed_in_ready();
    logic [NB-1:0] s = $urandom | 32'h1;
    i_req = 2'b01; i_seed_dv = 1'b1; i_seed_data = s;
    tick();
    i_seed_dv = 1'b0;
    vectors++;
    if (o_gnt !== 2'b00 || o_lfsr_seed_dv !== 1'b1) begin
      miscompares++; $display("FAIL seed_priority: gnt=%b sdv=%b required 00/1", o_gnt, o_lfsr_seed_dv);
    end
    cur_seed = s; grants = 0;
    for (int c = 0; c < WU + 1; c++) begin
      tick();
      vectors++;
      if (o_gnt !== 2'b00) begin
        miscompares++; $display("FAIL pending_during_warmup: gnt=%b required 00", o_gnt);
      end
    end
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reseed: ready=%b required 1", o_ready);
    end
    tick();
    vectors++;
    if (o_gnt !== 2'b01 || o_data !== expected_word(s, WU)) begin
      miscompares++; $display("FAIL pending_grant: gnt=%b data=%h required 01/%h", o_gnt, o_data, expected_word(s, WU));
    end
    last_idx = 0; grants++;
    i_req = 2'b00;
    tick();
  endtask

  task automatic test_seed_in_grant();
    logic [NB-1:0] s = $urandom | 32'h1;
    i_req = 2'b10;
    tick();
    vectors++;
    if (o_gnt !== 2'b10 || o_data !== expected_word(cur_seed, WU + grants)) begin
      miscompares++; $display("FAIL lone_grant: gnt=%b data=%h required 10/%h", o_gnt, o_data, expected_word(cur_seed, WU + grants));
    end
    last_idx = 1;
    i_req = 2'b00; i_seed_dv = 1'b1; i_seed_data = s;
    tick();
    i_seed_dv = 1'b0;
    vectors++;
    if (o_gnt !== 2'b00 || o_lfsr_seed_dv !== 1'b1 || o_lfsr_seed_data !== s || o_ready !== 1'b0) begin
      miscompares++; $display("FAIL seed_after_grant: gnt=%b sdv=%b sd=%h rdy=%b required 00/1/%h/0",
                              o_gnt, o_lfsr_seed_dv, o_lfsr_seed_data, o_ready, s);
    end
    cur_seed = s; grants = 0;
    repeat (WU + 1) tick();
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_grant_seed: ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_alarm();
    logic [NB-1:0] s = $urandom | 32'h1;
    logic [1:0] pend = 2'($urandom_range(1, 3));
    logic [1:0] exp_g = model_winner(pend, last_idx);
    i_req = pend;
    tick();
    vectors++;
    if (o_gnt !== exp_g) begin
      miscompares++; $display("FAIL pre_alarm_grant: gnt=%b required %b", o_gnt, exp_g);
    end
    last_idx = exp_g[1] ? 1 : 0;
    i_alarm = 1'b1;
    tick();
    i_alarm = 1'b0; i_req = 2'b11;
    vectors++;
    if (o_gnt !== 2'b00 || o_locked !== 1'b1 || o_lfsr_enable !== 1'b0 || o_ready !== 1'b0) begin
      miscompares++; $display("FAIL alarm_entry: gnt=%b lck=%b en=%b rdy=%b required 00/1/0/0", o_gnt, o_locked, o_lfsr_enable, o_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (o_gnt !== 2'b00 || o_locked !== 1'b1) begin
        miscompares++; $display("FAIL alarm_hold: gnt=%b lck=%b required 00/1", o_gnt, o_locked);
      end
    end
    i_seed_dv = 1'b1; i_alarm = 1'b1; i_seed_data = s;
    tick();
    vectors++;
    if (o_locked !== 1'b1 || o_lfsr_seed_dv !== 1'b0) begin
      miscompares++; $display("FAIL alarm_beats_seed: lck=%b sdv=%b required 1/0", o_locked, o_lfsr_seed_dv);
    end
    i_alarm = 1'b0;
    tick();
    i_seed_dv = 1'b0; i_req = 2'b00;
    vectors++;
    if (o_locked !== 1'b0 || o_lfsr_seed_dv !== 1'b1 || o_lfsr_seed_data !== s) begin
      miscompares++; $display("FAIL alarm_exit: lck=%b sdv=%b sd=%h required 0/1/%h", o_locked, o_lfsr_seed_dv, o_lfsr_seed_data, s);
    end
    cur_seed = s; grants = 0;
    repeat (WU + 1) tick();
    vectors++;
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_alarm: ready=%b required 1", o_ready);
    end
  endtask

  task automatic test_reset_in_warmup();
    i_seed_dv = 1'b1; i_seed_data = $urandom | 32'h1;
    tick();
    i_seed_dv = 1'b0;
    tick();
    i_rst = 1'b1; i_req = 2'b11;
    tick();
    vectors++;
    if (o_gnt !== 2'b00 || o_ready !== 1'b0 || o_lfsr_enable !== 1'b0 || o_lfsr_seed_dv !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_warmup: gnt=%b rdy=%b en=%b sdv=%b required 00/0/0/0", o_gnt, o_ready, o_lfsr_enable, o_lfsr_seed_dv);
    end
    i_rst = 1'b0;
    last_idx = 1;
    for (int c = 0; c < WU + 3; c++) begin
      tick();
      vectors++;
      if (o_gnt !== 2'b00 || o_ready !== 1'b0 || o_lfsr_enable !== 1'b0) begin
        miscompares++; $display("FAIL unseeded_after_reset: gnt=%b rdy=%b en=%b required 00/0/0", o_gnt, o_ready, o_lfsr_enable);
      end
    end
    i_req = 2'b00;
    do_seed($urandom | 32'h1);
    // Pointer is back at its reset value: requester 0 wins contention.
    i_req = 2'b11;
    tick();
    vectors++;
    if (o_gnt !== 2'b01) begin
      miscompares++; $display("FAIL pointer_after_reset: gnt=%b required 01", o_gnt);
    end
    last_idx = 0; grants++;
    i_req = 2'b00;
    tick();
  endtask

`ifdef LFSR_SCHED_WORD_CNT_EN
  task automatic test_word_cnt();
    do_seed($urandom | 32'h1);
    vectors++;
    if (o_word_cnt !== 16'd0) begin
      miscompares++; $display("FAIL word_cnt_seeded: got %0d required 0", o_word_cnt);
    end
    for (int g = 0; g < 3; g++) begin
      i_req = 2'b01;
      tick();
      i_req = 2'b00;
      tick();
    end
    last_idx = 0;
    vectors++;
    if (o_word_cnt !== 16'd3) begin
      miscompares++; $display("FAIL word_cnt_three: got %0d required 3", o_word_cnt);
    end
    i_seed_dv = 1'b1; i_seed_data = $urandom | 32'h1;
    tick();
    i_seed_dv = 1'b0;
    vectors++;
    if (o_word_cnt !== 16'd0) begin
      miscompares++; $display("FAIL word_cnt_reseed: got %0d required 0", o_word_cnt);
    end
    repeat (WU + 1) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_seed_to_ready();
    test_contention();
    test_random_requests();
    test_seed_in_ready();
    test_seed_in_grant();
    test_alarm();
    test_reset_in_warmup();
`ifdef LFSR_SCHED_WORD_CNT_EN
    test_word_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
